dsp_madd_sub_iter: RTL and testbench
====================================

// Module: dsp_madd_sub_iter
//
// PURPOSE
// Parametrised iterative multiply/accumulate unit: D = C +/- A*B or D = A*B, signed or unsigned,
// for W-bit operands, retiring STEP multiplier bits per cycle. It succeeds the fixed 32x32x64
// multiply-add/sub unit in the HI/LO datapath. New capabilities: selectable width and throughput,
// an accumulate-into-result mode, an explicit abort, and a done pulse.
//
// PARAMETERS
// W     32  operand width in bits; result is 2W+1 bits
// STEP  4   multiplier bits consumed per iteration; W % STEP == 0 required, else elaboration error
//
// PORTS
// clock     in   1     rising-edge clock
// reset     in   1     asynchronous, active-high reset
// A         in   W     multiplicand, sampled on the start edge only
// B         in   W     multiplier, sampled on the start edge only
// C         in   2W    addend/minuend, sampled on the start edge only
// sign      in   1     1 = two's-complement A, B, C; 0 = unsigned
// op        in   2     00 MUL, 01 MADD (C+P), 10 MSUB (C-P), 11 ACC (D[2W-1:0]+P)
// start     in   1     begin an operation on this edge
// abort     in   1     cancel any operation in flight
// busy      out  1     operation in progress
// done      out  1     one-cycle pulse when D updates
// D         out  2W+1  result register, held until the next completion
//
// BEHAVIOUR
// - Reset: state=IDLE, busy=0, done=0, D=0. Reset mid-operation discards all progress.
// - N = W/STEP. FSM: IDLE -> ITER (N cycles) -> FINAL (1 cycle) -> IDLE.
// - Start edge t: latch |A|, |B|, C, sign, op, product sign (A[W-1]^B[W-1] when sign=1).
//   Clear the partial product. busy=1 after edge t.
// - ITER: each edge adds |A| * (next STEP bits of |B|, LSB first) shifted into the 2W-bit
//   partial product.
// - FINAL (edge t+N+1): negate the product if its sign is set, extend to 2W+1 bits, combine,
//   then write D, set done=1 for one cycle, and set busy=0.
//   Total latency from the start edge to valid D is N+1 edges (9 at W=32, STEP=4).
// - Extension: sign=1 sign-extends P and C to 2W+1 bits; sign=0 zero-extends them.
//   - MUL: D = P extended.
//   - MADD: D = C + P.
//   - MSUB: D = C - P.
//   - Arithmetic is modulo 2^(2W+1); D[2W] is the carry/borrow or sign bit.
// - ACC: the operand is D[2W-1:0] as it stands at the start edge, treated like C.
//   ACC after reset adds to 0.
// - Start while busy: the current operation is dropped without a done pulse, and the new one
//   begins with full latency.
// - abort=1: return to IDLE on that edge with busy=0 and no done. D keeps its last completed
//   value. abort beats a simultaneous start; that start is ignored.
// - Start in the same cycle as FINAL: the FINAL result is dropped, and the new operation restarts.
// - start, abort and reset are all low: D never changes except at FINAL.
//
// TESTING (W=32, STEP=4)
// - MUL unsigned 0xffffffff*0xffffffff -> D=0x0_fffffffe00000001, done exactly 9 edges after start.
// - MUL signed 0x00001234*0xfffffff9 -> D=0x1_ffffffffffff8094; then signed
//   0xffffffff*0xffffffff -> D=0x0_0000000000000001.
// - MADD unsigned A=1, B=1, C=0xffffffffffffffff -> D=0x1_0000000000000000.
//   MSUB unsigned 0xffffffff*0xffffffff, C=0x1fffffffe -> D=0x1_00000003fffffffd.
// - ACC chain: MUL 5*7 (D=35), then ACC 2*3 -> D=41, then ACC signed 2*(-3) -> D=35.
// - Interrupt and retain: start MUL 0x12345678*0xffffffff, restart at cycle 3 with 0x1234*7
//   -> one done, D=0x7f6c. Next, start and abort at cycle 2 -> no done, D stays 0x7f6c after
//   10 idle cycles.
// - Reset asserted mid-ITER -> busy=0, done=0, D=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dsp_madd_sub_iter.sv
// dsp_madd_sub_iter: iterative signed/unsigned W x W multiply with add, subtract or accumulate,
// retiring STEP multiplier bits per cycle into a 2W+1-bit result register.
module dsp_madd_sub_iter #(
  parameter int W    = 32,
  parameter int STEP = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [2*W-1:0] C,
  input  logic           sign,
  input  logic [1:0]     op,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   D
);
  localparam int N  = W / STEP;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, ITER, FINAL} state_t;
  state_t state, state_n;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] a_sh, acc, cv, prod;
  logic [W-1:0]   b_sh;
  logic           sgn, neg;
  logic [1:0]     opr;
  logic [2*W:0]   pe, ce;
  if (W % STEP != 0) begin : g_bad
    $error("W must be a multiple of STEP");
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = abort ? IDLE :
              start ? ITER :
              (state == ITER && cnt == CW'(N - 1)) ? FINAL :
              (state == FINAL) ? IDLE : state;
  end
  assign busy = state != IDLE;
  // The iteration runs on magnitudes; the sign is reapplied once at FINAL.
  assign prod = neg ? -acc : acc;
  assign pe   = sgn ? {prod[2*W-1], prod} : {1'b0, prod};
  assign ce   = sgn ? {cv[2*W-1], cv} : {1'b0, cv};
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cv   <= '0;
      cnt  <= '0;
      sgn  <= 1'b0;
      neg  <= 1'b0;
      opr  <= 2'b00;
      done <= 1'b0;
      D    <= '0;
    end else begin
      done <= 1'b0;
      if (start && !abort) begin
        a_sh <= {{W{1'b0}}, (sign && A[W-1]) ? -A : A};
        b_sh <= (sign && B[W-1]) ? -B : B;
        cv   <= (op == 2'b11) ? D[2*W-1:0] : C;
        sgn  <= sign;
        neg  <= sign & (A[W-1] ^ B[W-1]);
        opr  <= op;
        acc  <= '0;
        cnt  <= '0;
      end else if (state == ITER) begin
        acc  <= acc + a_sh * {{(2*W-STEP){1'b0}}, b_sh[STEP-1:0]};
        a_sh <= a_sh << STEP;
        b_sh <= b_sh >> STEP;
        cnt  <= cnt + 1'b1;
      end else if (state == FINAL && !abort) begin
        D    <= (opr == 2'b00) ? pe : (opr == 2'b10) ? ce - pe : ce + pe;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dsp_madd_sub_iter.sv
// tb_dsp_madd_sub_iter: scoreboard bench; issued operations queue their expected result,
// a monitor pops and compares on every done pulse.
module tb_dsp_madd_sub_iter;
  logic        clock = 1'b0, reset = 1'b1;
  logic [31:0] opa = '0, opb = '0;
  logic [63:0] opc = '0;
  logic        sign = 1'b0, start = 1'b0, abort = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        busy, done;
  logic [64:0] D;
  int          cyc = 0, tests = 0, fails = 0;
  typedef struct { logic [64:0] d; int sc; } exp_t;
  exp_t        q[$];
  exp_t        me;
  logic [64:0] d_model = '0, d_saved = '0;
  logic [31:0] special [4] = '{32'h0, 32'h1, 32'h8000_0000, 32'hffff_ffff};

  dsp_madd_sub_iter #(.W(32), .STEP(4)) dut (
    .clock(clock), .reset(reset), .A(opa), .B(opb), .C(opc), .sign(sign), .op(op),
    .start(start), .abort(abort), .busy(busy), .done(done), .D(D)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference: exact product modulo 2^65, then the requested combination.
  function automatic logic [64:0] model(input logic [31:0] a, b, input logic [63:0] c,
                                        input logic s, input logic [1:0] o, input logic [64:0] dp);
    logic [64:0] p, x;
    logic [63:0] src;
    p   = s ? {{33{a[31]}}, a} * {{33{b[31]}}, b} : {33'b0, a} * {33'b0, b};
    src = (o == 2'b11) ? dp[63:0] : c;
    x   = s ? {src[63], src} : {1'b0, src};
    return (o == 2'b00) ? p : (o == 2'b10) ? x - p : x + p;
  endfunction

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done with D=%h want no done", D);
      end else begin
        me = q.pop_front();
        chk("D", D, me.d);
        chk("latency", 65'(cyc - me.sc), 65'd9);
      end
    end
  end

  task automatic issue(input logic [31:0] a, b, input logic [63:0] c, input logic s,
                       input logic [1:0] o);
    exp_t e;
    d_saved = d_model;
    e.d = model(a, b, c, s, o, d_model);
    opa = a; opb = b; opc = c; sign = s; op = o; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    e.sc = cyc;
    q.push_back(e);
    d_model = e.d;
  endtask

  task automatic drop();
    void'(q.pop_back());
    d_model = d_saved;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic wait_done();
    int i = 0;
    while (q.size() != 0 && i < 40) begin
      @(posedge clock); #1;
      i++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got %0d pending results want 0", q.size());
      q.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    return ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
  endfunction

  initial begin
    cycles(2);
    chk("reset_busy", 65'(busy), 65'd0);
    chk("reset_done", 65'(done), 65'd0);
    chk("reset_D", D, 65'd0);
    reset = 1'b0;
    cycles(1);
    issue(32'd3, 32'd4, 64'h0, 1'b0, 2'b11);
    wait_done();
    chk("acc_from_reset", D, 65'd12);
    issue(32'hffff_ffff, 32'hffff_ffff, 64'h0, 1'b0, 2'b00);
    wait_done();
    chk("mul_u_max", D, 65'h0_ffff_fffe_0000_0001);
    issue(32'h0000_1234, 32'hffff_fff9, 64'h0, 1'b1, 2'b00);
    wait_done();
    chk("mul_s_neg", D, 65'h1_ffff_ffff_ffff_8094);
    issue(32'hffff_ffff, 32'hffff_ffff, 64'h0, 1'b1, 2'b00);
    wait_done();
    chk("mul_s_m1", D, 65'h0_0000_0000_0000_0001);
    issue(32'd1, 32'd1, 64'hffff_ffff_ffff_ffff, 1'b0, 2'b01);
    wait_done();
    chk("madd_carry", D, 65'h1_0000_0000_0000_0000);
    issue(32'hffff_ffff, 32'hffff_ffff, 64'h1_ffff_fffe, 1'b0, 2'b10);
    wait_done();
    chk("msub_borrow", D, 65'h1_0000_0003_ffff_fffd);
    issue(32'd5, 32'd7, 64'h0, 1'b0, 2'b00);
    wait_done();
    chk("acc_chain0", D, 65'd35);
    issue(32'd2, 32'd3, 64'h0, 1'b0, 2'b11);
    wait_done();
    chk("acc_chain1", D, 65'd41);
    issue(32'd2, 32'hffff_fffd, 64'h0, 1'b1, 2'b11);
    wait_done();
    chk("acc_chain2", D, 65'd35);
    issue(32'h1234_5678, 32'hffff_ffff, 64'h0, 1'b0, 2'b00);
    cycles(2);
    drop();
    issue(32'h1234, 32'd7, 64'h0, 1'b0, 2'b00);
    wait_done();
    chk("restart", D, 65'h7f6c);
    issue(32'hdead_beef, 32'h1111_1111, 64'h0, 1'b0, 2'b00);
    cycles(1);
    opa = 32'h55; opb = 32'h66; start = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    drop();
    cycles(10);
    chk("abort_retain_D", D, 65'h7f6c);
    chk("abort_busy", 65'(busy), 65'd0);
    issue(32'd9, 32'd9, 64'h0, 1'b0, 2'b00);
    cycles(8);
    drop();
    issue(32'd10, 32'd10, 64'h0, 1'b0, 2'b11);
    wait_done();
    chk("final_restart_acc", D, 65'h7f6c + 65'd100);
    for (int i = 0; i < 40; i++) begin
      issue(pick(), pick(), {pick(), pick()}, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 4) == 0) begin
        cycles($urandom_range(0, 8));
        drop();
        issue(pick(), pick(), {pick(), pick()}, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
      wait_done();
      cycles($urandom_range(0, 2));
    end
    issue(32'h1234_5678, 32'h9abc_def0, 64'h0, 1'b1, 2'b01);
    cycles(3);
    #2 reset = 1'b1;
    #1;
    drop();
    d_model = '0;
    chk("midreset_busy", 65'(busy), 65'd0);
    chk("midreset_done", 65'(done), 65'd0);
    chk("midreset_D", D, 65'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    cycles(12);
    chk("midreset_quiet_D", D, 65'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
